// File: rtl/lp_solver.sv
// Brute-force 2-variable integer LP solver: maximises c1*x1 + c2*x2 over x1,x2 in 0..7.
// Optional macro LP_ARGMAX_EN adds out_x1/out_x2 reporting the optimising point.
module lp_solver #(
  parameter int NUM_CON = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic signed [5:0]   in_a1,
  input  logic signed [5:0]   in_a2,
  input  logic signed [11:0]  in_b,
  output logic                out_valid,
  output logic signed [11:0]  out_max_value
`ifdef LP_ARGMAX_EN
  ,
  output logic [2:0]          out_x1,
  output logic [2:0]          out_x2
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, OUT} state_t;

  localparam logic signed [11:0] MAX_INIT = 12'sh800;

  state_t state_reg, state_next;
  logic [1:0]         cnt_reg;
  logic [2:0]         x1_reg;
  logic signed [5:0]  c1_reg, c2_reg;
  logic signed [5:0]  row_a1_reg [4];
  logic signed [5:0]  row_a2_reg [4];
  logic signed [11:0] row_b_reg  [4];
  logic signed [11:0] max_reg;
  logic signed [3:0]  x1_s;
  logic signed [11:0] obj_val [8];
  logic [7:0]         feas;
  logic signed [11:0] best_val;
`ifdef LP_ARGMAX_EN
  logic [2:0]         bx1_reg, bx2_reg;
  logic [2:0]         best_x1, best_x2;
`endif

  assign x1_s = {1'b0, x1_reg};

  always_ff @(posedge clk) begin
    if (rst_n) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (in_valid) state_next = LOAD;
      LOAD:   if (in_valid && cnt_reg == 2'(NUM_CON - 1)) state_next = SEARCH;
      SEARCH: if (x1_reg == 3'd7) state_next = OUT;
      OUT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One candidate per x2 column, evaluated in parallel for the current x1.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_col
      localparam logic signed [3:0] X2_S = 4'(gi);
      logic signed [10:0] obj11;
      assign obj11       = c1_reg * x1_s + c2_reg * X2_S;
      assign obj_val[gi] = 12'(obj11);

      always_comb begin
        logic signed [10:0] lhs;
        logic signed [12:0] lhs13;
        logic signed [12:0] b13;
        feas[gi] = 1'b1;
        lhs      = '0;
        lhs13    = '0;
        b13      = '0;
        for (int r = 0; r < NUM_CON; r++) begin
          lhs   = row_a1_reg[r] * x1_s + row_a2_reg[r] * X2_S;
          lhs13 = 13'(lhs);
          b13   = 13'(row_b_reg[r]);
          if (lhs13 > b13) feas[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // Strictly-greater scan in ascending x2 keeps the earliest point on ties.
  always_comb begin
    best_val = max_reg;
`ifdef LP_ARGMAX_EN
    best_x1 = bx1_reg;
    best_x2 = bx2_reg;
`endif
    for (int i = 0; i < 8; i++) begin
      if (feas[i] && obj_val[i] > best_val) begin
        best_val = obj_val[i];
`ifdef LP_ARGMAX_EN
        best_x1 = x1_reg;
        best_x2 = 3'(i);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_reg       <= '0;
      x1_reg        <= '0;
      c1_reg        <= '0;
      c2_reg        <= '0;
      max_reg       <= MAX_INIT;
      out_valid     <= 1'b0;
      out_max_value <= '0;
`ifdef LP_ARGMAX_EN
      bx1_reg <= '0;
      bx2_reg <= '0;
      out_x1  <= '0;
      out_x2  <= '0;
`endif
    end else begin
      out_valid     <= 1'b0;
      out_max_value <= '0;
`ifdef LP_ARGMAX_EN
      out_x1 <= '0;
      out_x2 <= '0;
`endif
      case (state_reg)
        IDLE: if (in_valid) begin
          c1_reg  <= in_a1;
          c2_reg  <= in_a2;
          cnt_reg <= '0;
        end
        LOAD: if (in_valid) begin
          row_a1_reg[cnt_reg] <= in_a1;
          row_a2_reg[cnt_reg] <= in_a2;
          row_b_reg[cnt_reg]  <= in_b;
          cnt_reg             <= cnt_reg + 2'd1;
          x1_reg              <= '0;
          max_reg             <= MAX_INIT;
`ifdef LP_ARGMAX_EN
          bx1_reg <= '0;
          bx2_reg <= '0;
`endif
        end
        SEARCH: begin
          max_reg <= best_val;
          x1_reg  <= x1_reg + 3'd1;
`ifdef LP_ARGMAX_EN
          bx1_reg <= best_x1;
          bx2_reg <= best_x2;
`endif
        end
        OUT: begin
          out_valid     <= 1'b1;
          out_max_value <= max_reg;
`ifdef LP_ARGMAX_EN
          out_x1 <= bx1_reg;
          out_x2 <= bx2_reg;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lp_solver.sv
// Scoreboard bench for lp_solver: expected results queued at stimulus time, checked on out_valid.
module tb_lp_solver;

  localparam int NUM_CON = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic signed [5:0]   in_a1, in_a2;
  logic signed [11:0]  in_b;
  logic                out_valid;
  logic signed [11:0]  out_max_value;
`ifdef LP_ARGMAX_EN
  logic [2:0]          out_x1, out_x2;
`endif

  lp_solver #(.NUM_CON(NUM_CON)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_a1(in_a1), .in_a2(in_a2), .in_b(in_b),
    .out_valid(out_valid), .out_max_value(out_max_value)
`ifdef LP_ARGMAX_EN
    , .out_x1(out_x1), .out_x2(out_x2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int     mx;
    int     x1;
    int     x2;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint cycle_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check_value(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: exhaustive search, ties kept at smallest x1 then x2.
  task automatic model(input int c1, input int c2, input int ra1[NUM_CON],
                       input int ra2[NUM_CON], input int rb[NUM_CON],
                       output int mx, output int bx1, output int bx2);
    mx = -2048; bx1 = 0; bx2 = 0;
    for (int x1 = 0; x1 < 8; x1++)
      for (int x2 = 0; x2 < 8; x2++) begin
        bit ok = 1;
        for (int r = 0; r < NUM_CON; r++)
          if (ra1[r] * x1 + ra2[r] * x2 > rb[r]) ok = 0;
        if (ok && (c1 * x1 + c2 * x2) > mx) begin
          mx = c1 * x1 + c2 * x2; bx1 = x1; bx2 = x2;
        end
      end
  endtask

  task automatic send_problem(input int c1, input int c2, input int ra1[NUM_CON],
                              input int ra2[NUM_CON], input int rb[NUM_CON]);
    exp_t e;
    model(c1, c2, ra1, ra2, rb, e.mx, e.x1, e.x2);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a1 = 6'(c1); in_a2 = 6'(c2); in_b = 12'sd0;
    for (int r = 0; r < NUM_CON; r++) begin
      @(posedge clk); #1;
      in_a1 = 6'(ra1[r]); in_a2 = 6'(ra2[r]); in_b = 12'(rb[r]);
    end
    // Last row is sampled on the next edge (k); result is visible after edge k+9.
    e.cyc = cycle_cnt + 10;
    sb.push_back(e);
    $display("problem c=(%0d,%0d) expect max=%0d at (%0d,%0d)", c1, c2, e.mx, e.x1, e.x2);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a1 = '0; in_a2 = '0; in_b = '0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check_value("timeout", sb.size(), 0);
      sb.delete();
    end
    #1;
    check_value("idle_valid", out_valid, 0);
    check_value("idle_value", $signed(out_max_value), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check_value("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result max=%0d cycle=%0d", $signed(out_max_value), cycle_cnt);
        check_value("max_value", $signed(out_max_value), e.mx);
        check_value("latency", cycle_cnt, e.cyc);
`ifdef LP_ARGMAX_EN
        check_value("argmax_x1", out_x1, e.x1);
        check_value("argmax_x2", out_x2, e.x2);
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a1 = '0; in_a2 = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_valid", out_valid, 0);
    check_value("rst_value", $signed(out_max_value), 0);
    rst_n = 1'b0;

    send_problem(3, 2, '{1, 1, 0}, '{1, 0, 1}, '{4, 3, 3});            wait_done();
    send_problem(31, 31, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0});          wait_done();
    send_problem(-32, 5, '{-1, 0, 0}, '{0, 0, 0}, '{-2, 0, 0});        wait_done();
    send_problem(-1, -1, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0});          wait_done();
    send_problem(7, -3, '{0, 0, 0}, '{0, 0, 0}, '{-1, 0, 0});          wait_done();
    send_problem(0, 0, '{1, -1, 2}, '{1, 2, -1}, '{6, 5, 4});          wait_done();

    // Reset in the middle of the search: that problem must vanish silently.
    send_problem(3, 2, '{1, 1, 0}, '{1, 0, 1}, '{4, 3, 3});
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b0;
    check_value("midrst_valid", out_valid, 0);
    check_value("midrst_value", $signed(out_max_value), 0);
    repeat (15) @(posedge clk);
    send_problem(-32, 5, '{-1, 0, 0}, '{0, 0, 0}, '{-2, 0, 0});        wait_done();

    for (int n = 0; n < 8; n++) begin
      int c1, c2;
      int ra1[NUM_CON], ra2[NUM_CON], rb[NUM_CON];
      c1 = int'($urandom_range(63)) - 32;
      c2 = int'($urandom_range(63)) - 32;
      for (int r = 0; r < NUM_CON; r++) begin
        ra1[r] = int'($urandom_range(16)) - 8;
        ra2[r] = int'($urandom_range(16)) - 8;
        rb[r]  = int'($urandom_range(60)) - 10;
      end
      send_problem(c1, c2, ra1, ra2, rb);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lp_solver.md
Name:
lp_solver

Overview:
- Brute-force 2-variable integer linear-program solver.
- Accepts objective coefficients, then NUM_CON constraint rows, on a serial in_valid stream.
- Maximises c1*x1 + c2*x2 over integer x1, x2 in 0..7, subject to a1*x1 + a2*x2 <= b for every row.
- Returns the maximum as a single-cycle result pulse; a standalone compute block fed by a stimulus/controller.

Parameters:
- NUM_CON, 3, number of constraint rows per problem (legal 1..4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-high reset; resets when rst_n==1, sampled on rising clk.
- in_valid  input  1  high for exactly 1+NUM_CON consecutive cycles per problem.
- in_a1  input  6 signed  cycle 0: c1; cycles 1..NUM_CON: a1 of the row.
- in_a2  input  6 signed  cycle 0: c2; cycles 1..NUM_CON: a2 of the row.
- in_b  input  12 signed  cycle 0: ignored; cycles 1..NUM_CON: b of the row.
- out_valid  output  1  one-cycle result strobe.
- out_max_value  output  12 signed  maximum objective value; 0 when out_valid low.

Behaviour:
- Reset:
  - out_valid=0, out_max_value=0; FSM to IDLE.
  - Any in-flight problem is discarded; no out_valid for it.
- FSM: IDLE -> LOAD (capture rows) -> SEARCH (8 cycles) -> OUT (1 cycle) -> IDLE.
- Loading:
  - First in_valid cycle registers c1, c2.
  - Next NUM_CON cycles register rows 0..NUM_CON-1 in arrival order.
  - in_valid asserted outside IDLE/LOAD is ignored.
- Search:
  - One x1 value per cycle, x1=0..7 ascending.
  - All 8 x2 values evaluated in parallel per cycle.
- Feasibility:
  - Point feasible iff for all rows: a1*x1 + a2*x2 <= b.
  - LHS computed at 11 bits signed; compare against b sign-extended to 13 bits; no overflow possible.
- Objective:
  - c1*x1 + c2*x2, computed at 11 bits signed, sign-extended to 12.
  - Running max register initialised to -2048 (12'h800).
  - Updated only by feasible points with strictly greater value.
- Output timing:
  - Let edge k sample the last in_valid cycle. out_valid=1 on the cycle after edge k+9, for exactly one cycle, then returns to 0.
  - Next problem may start (in_valid) the cycle after out_valid.
- Infeasible problem (no feasible point): out_max_value = -2048.
- Value range: max |objective| = 32*7*2 = 448, fits 12 bits.

Optional Feature:
- Macro LP_ARGMAX_EN.
- Defined:
  - Adds outputs out_x1 [2:0] and out_x2 [2:0] (unsigned), the optimising point.
  - Ties resolved by smallest x1, then smallest x2.
  - Both are 0 when out_valid is low or the problem is infeasible.
- Undefined: ports absent; identical max-value behaviour.

Test Plan:
- c=(3,2); rows (1,1,4),(1,0,3),(0,1,3) -> out_max_value=11 (argmax 3,1); out_valid exactly 9 cycles after last input cycle.
- c=(31,31); rows all (0,0,0) -> 434 (argmax 7,7).
- c=(-32,5); rows (-1,0,-2),(0,0,0),(0,0,0) -> -29 (argmax 2,7).
- c=(-1,-1); rows all (0,0,0) -> 0 (argmax 0,0).
- Any c; row (0,0,-1) -> -2048, out_valid still pulses once.
- rst_n=1 pulsed mid-SEARCH -> no out_valid for that problem, outputs 0; following problem solved correctly.
